// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses, CON bit
// positions and the state encoding used by both serial FSMs.
package uart_mmio_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_RXV = 2;
  localparam int CON_TXB = 3;
  localparam int CON_OVR = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] con_word(input logic rxv, input logic txb, input logic ovr);
    logic [31:0] w;
    w          = '0;
    w[CON_RXV] = rxv;
    w[CON_TXB] = txb;
    w[CON_OVR] = ovr;
    return w;
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// MEM-stage data bus as seen by the UART peripheral.
// Handshake: MemRead/MemWrite are the valid strobes for one cycle each; the
// responder is always ready, writes take effect on that rising edge and
// ReadData answers combinationally within the same cycle.
interface uart_mmio_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemRead, output MemWrite, output Address, output WriteData,
                  input ReadData);
  modport slave  (input MemRead, input MemWrite, input Address, input WriteData,
                  output ReadData);
endinterface

// File: rtl/uart_rx_core.sv
// Serial receiver: 2-flop synchroniser, start/data/stop FSM and a one-cycle
// done pulse with frame_ok reporting the sampled stop bit.
module uart_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        done,
  output logic        frame_ok,
  output logic [7:0]  data,
  output uart_state_e state
);

  localparam int             CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  LAST      = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic          sync1, sync2, prev;
  uart_state_e   state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;

  // Synchronisers reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    done       = 1'b0;
    frame_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prev && !sync2) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2 ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          shift_next = {sync2, shift[7:1]};
          if (bit_cnt == 3'd7) state_next = ST_STOP;
          else                 bit_next   = bit_cnt + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == LAST) begin
          done       = 1'b1;
          frame_ok   = sync2;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/uart_mmio.sv
// UART peripheral on the MEM-stage bus: TXD/RXD/CON registers, the transmit
// FSM and the read mux; reception is delegated to uart_rx_core.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          clk,
  input  logic          reset,
  uart_mmio_if.slave    bus,
  input  logic          uart_rx,
  output logic          uart_tx,
  output uart_state_e   tx_state,
  output uart_state_e   rx_state
);

  localparam int            BAUD_DIV = CLK_FREQ / BAUD;
  localparam int            CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST     = CW'(BAUD_DIV - 1);

  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, rd_rxd, rd_con;
  logic unused_wdata;

  assign hit_txd      = (bus.Address == ADDR_TXD);
  assign hit_rxd      = (bus.Address == ADDR_RXD);
  assign hit_con      = (bus.Address == ADDR_CON);
  assign wr_txd       = bus.MemWrite && hit_txd;
  assign rd_rxd       = bus.MemRead && hit_rxd;
  assign rd_con       = bus.MemRead && hit_con;
  assign unused_wdata = ^bus.WriteData[31:8];

  // ---------------- transmitter ----------------
  uart_state_e   tx_state_next;
  logic [CW-1:0] tx_baud, tx_baud_next;
  logic [2:0]    tx_bit, tx_bit_next;
  logic [7:0]    txd_latch, txd_latch_next;
  logic          tx_line, tx_line_next;
  logic          tx_busy, tx_last, tx_accept;

  assign tx_busy   = (tx_state != ST_IDLE);
  assign tx_last   = (tx_state == ST_STOP) && (tx_baud == LAST);
  // The final stop-bit cycle may already take the next byte, so frames can abut.
  assign tx_accept = wr_txd && (!tx_busy || tx_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state  <= ST_IDLE;
      tx_baud   <= '0;
      tx_bit    <= '0;
      txd_latch <= '0;
      tx_line   <= 1'b1;
    end else begin
      tx_state  <= tx_state_next;
      tx_baud   <= tx_baud_next;
      tx_bit    <= tx_bit_next;
      txd_latch <= txd_latch_next;
      tx_line   <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state;
    tx_baud_next   = tx_baud;
    tx_bit_next    = tx_bit;
    txd_latch_next = txd_latch;
    tx_line_next   = tx_line;
    if (tx_accept) begin
      tx_state_next  = ST_START;
      tx_baud_next   = '0;
      tx_bit_next    = '0;
      txd_latch_next = bus.WriteData[7:0];
      tx_line_next   = 1'b0;
    end else begin
      case (tx_state)
        ST_START: begin
          if (tx_baud == LAST) begin
            tx_state_next = ST_DATA;
            tx_baud_next  = '0;
            tx_bit_next   = '0;
            tx_line_next  = txd_latch[0];
          end else begin
            tx_baud_next = tx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_baud == LAST) begin
            tx_baud_next = '0;
            if (tx_bit == 3'd7) begin
              tx_state_next = ST_STOP;
              tx_line_next  = 1'b1;
            end else begin
              tx_bit_next  = tx_bit + 3'd1;
              tx_line_next = txd_latch[tx_bit + 3'd1];
            end
          end else begin
            tx_baud_next = tx_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_baud == LAST) begin
            tx_state_next = ST_IDLE;
            tx_baud_next  = '0;
          end else begin
            tx_baud_next = tx_baud + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign uart_tx = tx_line;

  // ---------------- receiver and flags ----------------
  logic       rx_done, rx_ok;
  logic [7:0] rx_data, rx_byte;
  logic       rx_valid, rx_overrun, rx_new;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .done     (rx_done),
    .frame_ok (rx_ok),
    .data     (rx_data),
    .state    (rx_state)
  );

  assign rx_new = rx_done && rx_ok;

  // An RXD load racing a new byte consumes the old one, so it is not an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_new) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
      end else if (rd_rxd) begin
        rx_valid <= 1'b0;
      end
      if (rx_new && rx_valid && !rd_rxd) rx_overrun <= 1'b1;
      else if (rd_con)                   rx_overrun <= 1'b0;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (reset) begin
      if (hit_txd)      bus.ReadData = {24'b0, txd_latch};
      else if (hit_rxd) bus.ReadData = {24'b0, rx_byte};
      else if (hit_con) bus.ReadData = con_word(rx_valid, tx_busy, rx_overrun);
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at BAUD_DIV=16: directed register/line scenarios plus a
// randomized mix, checked against a cycle-count reference model.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam int BD = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  uart_state_e tx_state, rx_state;
  int          cyc = 0;

  uart_mmio_if bus ();

  uart_mmio #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .tx_state (tx_state),
    .rx_state (rx_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard and model ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  tx_q[$];

  logic [7:0]  m_txd, m_rxb;
  bit          m_rxv, m_ovr;
  int          tx_free;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_txd   = 8'h00;
    m_rxb   = 8'h00;
    m_rxv   = 1'b0;
    m_ovr   = 1'b0;
    tx_free = 0;
    tx_q.delete();
  endtask

  // ---------------- drivers ----------------
  // One bus cycle: strobes are sampled by the DUT at edge cyc+1.
  task automatic bus_op(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input string name);
    logic [31:0] e;
    bit          busy;
    @(posedge clk);
    #1;
    bus.MemWrite  = wr;
    bus.MemRead   = rd;
    bus.Address   = a;
    bus.WriteData = d;
    e    = 32'h0;
    busy = (cyc < tx_free);
    if (rd) begin
      if (reset) begin
        if (a == 32'h4000_0018)      e = {24'h0, m_txd};
        else if (a == 32'h4000_001C) begin e = {24'h0, m_rxb}; m_rxv = 1'b0; end
        else if (a == 32'h4000_0020) begin
          e = (32'(m_ovr) << 4) | (32'(busy) << 3) | (32'(m_rxv) << 2);
          m_ovr = 1'b0;
        end
      end
      exp_q.push_back(e);
      name_q.push_back(name);
    end
    if (wr && reset && a == 32'h4000_0018 && (cyc + 1 >= tx_free)) begin
      m_txd   = d[7:0];
      tx_free = cyc + 1 + 10 * BD;
      tx_q.push_back(d[7:0]);
    end
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.Address  = 32'h0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 uart_rx = fr[i];
      repeat (BD - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    if (stop) begin
      if (m_rxv) m_ovr = 1'b1;
      m_rxv = 1'b1;
      m_rxb = b;
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (bus.MemRead === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_unexpected: got %h expected no read", bus.ReadData);
      end else begin
        check(name_q.pop_front(), bus.ReadData, exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!reset) ab = 1'b1;
    end
  endtask

  // Decodes each frame on uart_tx at mid-bit and compares with the model's byte.
  initial begin
    logic [7:0] got;
    logic       s0, sp;
    bit         ab;
    #20;
    forever begin
      @(negedge uart_tx);
      ab = 1'b0;
      wait_cyc(8, ab);
      s0 = uart_tx;
      for (int i = 0; i < 8; i++) begin
        wait_cyc(BD, ab);
        got[i] = uart_tx;
      end
      wait_cyc(BD, ab);
      sp = uart_tx;
      if (!ab) begin
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got frame %h expected none", got);
        end else begin
          check("tx_frame", {22'h0, sp, got, s0}, {22'h0, 1'b1, tx_q.pop_front(), 1'b0});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] addrs[6];

  initial begin
    addrs = '{32'h4000_0018, 32'h4000_001C, 32'h4000_0020,
              32'h4000_0014, 32'h4000_0024, 32'hC000_0018};
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = 32'h0; bus.WriteData = 32'h0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    bus_op(0, 1, ADDR_CON, 0, "con_in_reset");
    #1 check("tx_in_reset", uart_tx, 1);
    bus_idle(1);
    @(posedge clk);
    #1 reset = 1'b1;
    bus_op(0, 1, ADDR_TXD, 0, "reset_txd");
    bus_op(0, 1, ADDR_RXD, 0, "reset_rxd");
    bus_op(0, 1, ADDR_CON, 0, "reset_con");
    bus_idle(1);
    check("reset_tx_state", 32'(tx_state), 32'(ST_IDLE));
    check("reset_tx_line", uart_tx, 1);

    // TX 0xA5: busy window probed every cycle up to and past the clearing edge
    bus_op(1, 0, ADDR_TXD, 32'h0000_00A5, "");
    for (int i = 0; i < 161; i++) bus_op(0, 1, ADDR_CON, 0, "tx_busy_window");
    bus_idle(20);

    // TX drop: second store five cycles in is ignored
    bus_op(1, 0, ADDR_TXD, 32'h11, "");
    bus_idle(4);
    bus_op(1, 0, ADDR_TXD, 32'h22, "");
    bus_op(0, 1, ADDR_TXD, 0, "txd_after_drop");
    bus_idle(180);

    // Back-to-back: one cycle early is dropped, the clearing cycle is accepted
    bus_op(1, 0, ADDR_TXD, 32'h5A, "");
    bus_idle(158);
    bus_op(1, 0, ADDR_TXD, 32'hC3, "");
    bus_op(1, 0, ADDR_TXD, 32'h3E, "");
    bus_op(0, 1, ADDR_TXD, 0, "txd_back_to_back");
    bus_idle(340);

    // RX single byte
    send_rx(8'h3C, 1);
    bus_op(0, 1, ADDR_CON, 0, "rx_con_valid");
    bus_op(0, 1, ADDR_RXD, 0, "rx_byte");
    bus_op(0, 1, ADDR_CON, 0, "rx_con_cleared");
    bus_op(1, 0, ADDR_RXD, 32'hFF, "");
    bus_op(1, 0, ADDR_CON, 32'hFF, "");
    bus_idle(1);

    // Overrun
    send_rx(8'h01, 1);
    send_rx(8'h02, 1);
    bus_op(0, 1, ADDR_CON, 0, "ovr_con");
    bus_op(0, 1, ADDR_RXD, 0, "ovr_rxd");
    bus_op(0, 1, ADDR_CON, 0, "ovr_con_after_rxd");
    bus_op(0, 1, ADDR_CON, 0, "ovr_con_cleared");
    bus_idle(1);

    // RXD load in the completion cycle: old byte returned, no overrun
    send_rx(8'h66, 1);
    fork
      send_rx(8'h5B, 1);
      begin
        @(posedge clk); #1;
        repeat (153) @(posedge clk);
        bus_op(0, 1, ADDR_RXD, 0, "rxd_same_cycle");
        bus_idle(1);
      end
    join
    bus_op(0, 1, ADDR_CON, 0, "rxd_race_con");
    bus_op(0, 1, ADDR_RXD, 0, "rxd_race_byte");
    bus_idle(1);

    // CON load in the overrun cycle: set wins
    send_rx(8'h77, 1);
    fork
      send_rx(8'h88, 1);
      begin
        @(posedge clk); #1;
        repeat (153) @(posedge clk);
        bus_op(0, 1, ADDR_CON, 0, "con_same_cycle");
        bus_idle(1);
      end
    join
    bus_op(0, 1, ADDR_CON, 0, "con_race_ovr");
    bus_op(0, 1, ADDR_RXD, 0, "con_race_byte");
    bus_op(0, 1, ADDR_CON, 0, "con_race_after");
    bus_op(0, 1, ADDR_CON, 0, "con_race_clear");
    bus_idle(1);

    // False start glitch and framing error
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    bus_op(0, 1, ADDR_CON, 0, "glitch_con");
    bus_idle(1);
    check("glitch_rx_state", 32'(rx_state), 32'(ST_IDLE));
    send_rx(8'h99, 0);
    bus_op(0, 1, ADDR_CON, 0, "framing_con");
    bus_op(0, 1, ADDR_RXD, 0, "framing_rxd");
    bus_idle(1);

    // Reset in the middle of both frames
    bus_op(1, 0, ADDR_TXD, 32'hF0, "");
    bus_idle(1);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1 check("tx_reset_midframe", uart_tx, 1);
    bus_op(0, 1, ADDR_CON, 0, "con_reset_midframe");
    bus_idle(1);
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    bus_op(0, 1, ADDR_CON, 0, "con_after_reset");
    bus_op(0, 1, ADDR_TXD, 0, "txd_after_reset");
    bus_idle(40);
    check("tx_idle_after_reset", uart_tx, 1);
    bus_idle(200);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          bus_op(1, 0, ADDR_TXD, $urandom, "");
          bus_idle($urandom_range(1, 200));
        end
        1: begin
          bus_idle(1);
          send_rx(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
        2: bus_op(0, 1, addrs[$urandom_range(0, 5)], 0, "rand_read");
        3: bus_op(1, 0, addrs[$urandom_range(1, 5)], $urandom, "");
        default: bus_idle($urandom_range(1, 50));
      endcase
    end
    bus_op(0, 1, ADDR_CON, 0, "final_con");
    bus_op(0, 1, ADDR_RXD, 0, "final_rxd");
    bus_op(0, 1, ADDR_TXD, 0, "final_txd");
    bus_idle(400);
    check("tx_frames_drained", tx_q.size(), 0);
    check("reads_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
